// File: rtl/ssi_pkg.sv
// SSI slave shared definitions: one-hot FSM state encoding and the
// default position-word width and monoflop timeout.
package ssi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        WAIT  = 3'b100
    } state_t;

    localparam int DEF_DATA_W   = 23;
    localparam int DEF_MONO_CNT = 4000;

endpackage

// File: rtl/ssi_edge_sync.sv
// Two-flop synchronizer for the SSI master clock plus rise/fall detector.
// Ports: clk, rst_n, clk_in (async) -> level, rise, fall (clk domain).
module ssi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // The line idles high, so all flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~prev;
    assign fall  = ~sync2 & prev;

endmodule

// File: rtl/ssi_slave.sv
// SSI slave: shifts a latched position word out MSB first on master clocks.
// Ports: clk, rst_n, clk_in, position -> data_out, busy, frame_done.
// Optional even-parity bit after the word: define SSI_SLAVE_PARITY_EN.
module ssi_slave
    import ssi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MONO_CNT = DEF_MONO_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_in,
    input  logic [DATA_W-1:0] position,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

`ifdef SSI_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int CW = $clog2(DATA_W + 2);
    localparam int MW = $clog2(MONO_CNT + 1);
    localparam logic [CW-1:0] NBITS    = CW'(DATA_W);
    localparam logic [CW-1:0] LAST     = CW'(DATA_W + PAR_BITS);
    localparam logic [MW-1:0] MONO_MAX = MW'(MONO_CNT);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [MW-1:0]     mono;
    logic              timeout;
    logic              dout_nxt;
    logic              done_nxt;
    logic              load;
    logic              shift;
    logic              par_bit;
    logic              level;
    logic              rise;
    logic              fall;

    ssi_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_in (clk_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // Monoflop: time spent high since the last master edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mono <= '0;
        end else if (rise | fall) begin
            mono <= '0;
        end else if (level && !timeout) begin
            mono <= mono + 1'b1;
        end
    end

    assign timeout = (mono == MONO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = data_out;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    load      = 1'b1;
                    dout_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (timeout) begin
                    dout_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (rise) begin
                    if (cnt == LAST) begin
                        dout_nxt  = 1'b0;
                        state_nxt = WAIT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt < NBITS) begin
                            dout_nxt = sreg[DATA_W-1];
                            shift    = 1'b1;
                        end else begin
                            dout_nxt = par_bit;
                        end
                    end
                end
            end
            WAIT: begin
                if (timeout) begin
                    dout_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                dout_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg       <= '0;
            cnt        <= '0;
            data_out   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            data_out   <= dout_nxt;
            frame_done <= done_nxt;
            if (load) begin
                sreg <= position;
            end else if (shift) begin
                sreg <= {sreg[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef SSI_SLAVE_PARITY_EN
    // Parity taken from the word as latched, before any shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= ^position;
        end
    end
`else
    assign par_bit = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
